// File: rtl/dmem_lsu.sv
// dmem_lsu: single-port byte-addressable data memory with a load/store unit.
// Three-state handshake (IDLE -> ACCESS -> RESP). Sub-word stores use per-lane
// byte enables. Loads are right-justified and then sign- or zero-extended.
// Misaligned or illegal requests return an error and leave memory untouched.
module dmem_lsu #(
    parameter int ADDRESS_SIZE = 10,
    parameter int N            = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [N-1:0]            req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [N-1:0]            resp_rdata,
    output logic                    resp_err
);
    localparam int LANES = N / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int DEPTH = (2 ** ADDRESS_SIZE) / LANES;
    localparam int IDX_W = ADDRESS_SIZE - OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [N-1:0]            wdata_q, wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [N-1:0]            resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic [N-1:0]            mem_q [DEPTH];

    logic                    err_s;
    logic [OFF_W-1:0]        off_s;
    logic [IDX_W-1:0]        idx_s;
    logic [N-1:0]            word_s;
    logic [N-1:0]            shifted_s;
    logic [N-1:0]            load_s;
    logic [N-1:0]            wshift_s;
    logic [LANES-1:0]        be_s;
    logic                    sign_s;
    int                      nbits_s;

    // An address is aligned when its low log2(size) bits are all zero.
    function automatic logic misaligned_f(input logic [ADDRESS_SIZE-1:0] a,
                                          input logic [1:0] s);
        logic m;
        case (s)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            2'd3:    m = |a[2:0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Address decode, error detection, load extraction and store lane enables.
    always_comb begin
        off_s     = addr_q[OFF_W-1:0];
        idx_s     = addr_q[ADDRESS_SIZE-1:OFF_W];
        err_s     = misaligned_f(addr_q, size_q) | ((N == 32) && (size_q == 2'b11));
        word_s    = mem_q[idx_s];
        shifted_s = word_s >> {off_s, 3'b000};
        wshift_s  = wdata_q << {off_s, 3'b000};
        case (size_q)
            2'd0:    begin nbits_s = 8;  sign_s = shifted_s[7];   end
            2'd1:    begin nbits_s = 16; sign_s = shifted_s[15];  end
            2'd2:    begin nbits_s = 32; sign_s = shifted_s[31];  end
            default: begin nbits_s = N;  sign_s = shifted_s[N-1]; end
        endcase
        // A full-width load never extends, so req_unsigned is irrelevant there.
        sign_s = sign_s & ~uns_q;
        for (int i = 0; i < N; i++) begin
            load_s[i] = (i < nbits_s) ? shifted_s[i] : sign_s;
        end
        for (int i = 0; i < LANES; i++) begin
            be_s[i] = (i >= int'(off_s)) && (i < int'(off_s) + (nbits_s / 8));
        end
    end

    // Next-state and response logic; request fields are latched only on acceptance.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = err_s;
                if (err_s || we_q) begin
                    resp_rdata_d = {N{1'b0}};
                end else begin
                    resp_rdata_d = load_s;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= {ADDRESS_SIZE{1'b0}};
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= {N{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {N{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Masked byte-lane store; reset blocks the write and never clears contents.
    always_ff @(posedge clk) begin
        if (rst && (state_q == ACCESS) && we_q && !err_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wshift_s[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu (N=64, ADDRESS_SIZE=10): the driver pushes
// hand-computed responses; an independent monitor pops them on each handshake.
module tb_dmem_lsu;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    dmem_lsu #(.ADDRESS_SIZE(10), .N(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed response against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
            end
        end
    end

    task automatic drive(input logic we, input logic [9:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wd);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic do_req(input logic we, input logic [9:0] addr, input logic [1:0] size,
                          input logic uns, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_err);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        drive(we, addr, size, uns, wd);
        e.rd  = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_not_yet", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid", {63'd0, resp_valid}, 64'd1);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 10'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 64'd0;
        resp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", {63'd0, resp_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);

        do_req(1'b1, 10'h068, 2'd3, 1'b0, 64'h0000000000015F90, 64'd0, 1'b0);
        do_req(1'b0, 10'h068, 2'd3, 1'b0, 64'd0, 64'h0000000000015F90, 1'b0);
        do_req(1'b1, 10'h068, 2'd3, 1'b0, 64'h1122334455667788, 64'd0, 1'b0);
        do_req(1'b1, 10'h069, 2'd0, 1'b0, 64'hCCCCCCCCCCCCCCAB, 64'd0, 1'b0);
        do_req(1'b0, 10'h068, 2'd3, 1'b0, 64'd0, 64'h112233445566AB88, 1'b0);
        do_req(1'b0, 10'h069, 2'd0, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0);
        do_req(1'b0, 10'h069, 2'd0, 1'b1, 64'd0, 64'h00000000000000AB, 1'b0);
        do_req(1'b0, 10'h06A, 2'd1, 1'b0, 64'd0, 64'h0000000000005566, 1'b0);
        do_req(1'b1, 10'h06A, 2'd2, 1'b0, 64'h00000000FFFFFFFF, 64'd0, 1'b1);
        do_req(1'b0, 10'h06B, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
        do_req(1'b0, 10'h068, 2'd3, 1'b0, 64'd0, 64'h112233445566AB88, 1'b0);
        do_req(1'b1, 10'h070, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        do_req(1'b0, 10'h070, 2'd2, 1'b0, 64'd0, 64'hFFFFFFFF89ABCDEF, 1'b0);
        do_req(1'b0, 10'h072, 2'd1, 1'b1, 64'd0, 64'h00000000000089AB, 1'b0);
        do_req(1'b0, 10'h072, 2'd1, 1'b0, 64'd0, 64'hFFFFFFFFFFFF89AB, 1'b0);
        do_req(1'b1, 10'h06F, 2'd0, 1'b0, 64'h000000000000005A, 64'd0, 1'b0);
        do_req(1'b0, 10'h068, 2'd3, 1'b0, 64'd0, 64'h5A2233445566AB88, 1'b0);
        do_req(1'b0, 10'h06C, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
        do_req(1'b0, 10'h06C, 2'd2, 1'b1, 64'd0, 64'h000000005A223344, 1'b0);

        // Back-pressure: hold resp_ready low while a competing store is offered.
        begin
            exp_t e;
            @(negedge clk);
            resp_ready = 1'b0;
            drive(1'b0, 10'h068, 2'd3, 1'b0, 64'd0);
            e.rd  = 64'h5A2233445566AB88;
            e.err = 1'b0;
            exp_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            drive(1'b1, 10'h070, 2'd1, 1'b0, 64'h000000000000DEAD);
            for (int k = 0; k < 3; k++) begin
                chk("stall_valid", {63'd0, resp_valid}, 64'd1);
                chk("stall_rdata", resp_rdata, 64'h5A2233445566AB88);
                chk("stall_err", {63'd0, resp_err}, 64'd0);
                chk("stall_ready", {63'd0, req_ready}, 64'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk);
        end

        // Reset during ACCESS: the store must be dropped and outputs cleared.
        @(negedge clk);
        drive(1'b1, 10'h070, 2'd1, 1'b0, 64'h000000000000FFFF);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_mid_rdata", resp_rdata, 64'd0);
        chk("rst_mid_err", {63'd0, resp_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);

        do_req(1'b0, 10'h070, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter ADDRESS_SIZE, default 10: byte-address width; capacity is 2**ADDRESS_SIZE bytes.
REQ-002 Parameter N, default 64: data width in bits, legal values 32 or 64; lanes = N/8; depth = 2**ADDRESS_SIZE / lanes words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDRESS_SIZE  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 dword.
REQ-010 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  N  store data, right-justified.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_rdata  output  N  load result, right-justified and extended.
REQ-015 resp_err  output  1  request was misaligned or illegal.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE -> ACCESS on an edge with req_valid=1; request fields SHALL be captured at that edge.
REQ-018 ACCESS -> RESP unconditionally at the next edge, where the memory read or masked write SHALL occur.
REQ-019 RESP drives resp_valid=1; RESP -> IDLE on an edge with resp_ready=1; otherwise resp_valid, resp_rdata and resp_err SHALL hold stable.
REQ-020 Latency: a request accepted at edge T SHALL give resp_valid=1 from edge T+2; minimum spacing between requests is 3 cycles.
REQ-021 Alignment rule: req_addr SHALL be a multiple of the access size (1/2/4/8 bytes), or the request is misaligned.
REQ-022 When N=32, req_size=11 SHALL be illegal.
REQ-023 A misaligned or illegal request SHALL set resp_err=1, force resp_rdata=0, and leave memory unchanged.
REQ-024 Lane offset = req_addr mod lanes; word index = req_addr / lanes; byte lanes are little-endian.
REQ-025 Store: only the size-many byte lanes starting at the lane offset SHALL be written, taken from the low bytes of req_wdata; all other lanes keep their values.
REQ-026 Store response: resp_rdata=0; resp_err as defined in REQ-023.
REQ-027 Load: the selected bytes SHALL be shifted to bit 0 and extended to N bits per req_unsigned; a dword load ignores req_unsigned.
REQ-028 Inputs SHALL be ignored outside the IDLE acceptance edge; changes after capture SHALL have no effect.
REQ-029 Memory SHALL be a single-port array of depth words × N bits; there is no read/write collision because there is one access per request.

Reset
REQ-030 While rst=0 at an edge: state -> IDLE, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the first edge with rst=1.
REQ-031 Reset SHALL take priority over the memory access; a store in ACCESS at a reset edge SHALL NOT be written.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification (N=64, ADDRESS_SIZE=10)
REQ-033 Store dword 0x0000000000015F90 at 0x068, then load dword at 0x068 -> resp_rdata=0x0000000000015F90, resp_err=0, resp_valid two edges after acceptance.
REQ-034 Store dword 0x1122334455667788 at 0x068, store byte 0xAB at 0x069, load dword at 0x068 -> 0x112233445566AB88.
REQ-035 After REQ-034, signed byte load at 0x069 -> 0xFFFFFFFFFFFFFFAB; unsigned byte load -> 0x00000000000000AB; signed half load at 0x06A -> 0x0000000000005566.
REQ-036 Word store at 0x06A and half load at 0x06B -> both give resp_err=1, resp_rdata=0; a following dword load at 0x068 is unchanged at 0x112233445566AB88.
REQ-037 Hold resp_ready=0 for 3 cycles during a load -> resp_valid, resp_rdata and resp_err stay stable and req_ready=0; a new request presented meanwhile is not accepted.
REQ-038 Store 0xFFFF at 0x070 with rst=0 at the ACCESS edge -> all outputs at reset values; a later load at 0x070 returns the prior contents.
